video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator: the successor to the fixed 384x263 arcade timing block.
//  Produces pixel/line counters, blanking, syncs and a display-enable signal for video pipelines.
//  Per-core H/V geometry comes from parameters; sync polarity is also a parameter.
//  Signed screen-centring offsets are latched once per frame, so the picture never tears.
//  Sits between the clock-enable generator and the tile/sprite/palette pipelines and the scandoubler.
// PARAMETERS
//  CW            9    counter width, bits (hcount/vcount)
//  H_TOTAL       384  pixels per line; hcount runs 0..H_TOTAL-1
//  H_ACT_START   17   first active pixel
//  H_ACT_END     273  first blanked pixel after the active area
//  H_SYNC_START  309  HS assert position at zero offset
//  H_SYNC_END    341  HS deassert position at zero offset
//  V_TOTAL       263  lines per frame (progressive) or per even field
//  V_ACT_START   16   first active line
//  V_ACT_END     240  first blanked line after the active area
//  V_SYNC_START  250  VS assert line at zero offset
//  V_SYNC_END    253  VS deassert line at zero offset
//  HS_POL        0    HS active level
//  VS_POL        0    VS active level
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  ce_pix      in   1   pixel clock enable; all counting is qualified by it
//  hoffs       in   4   signed horizontal sync offset (-8..+7 pixels); positive moves the picture right
//  voffs       in   4   signed vertical sync offset (-8..+7 lines)
//  interlace   in   1   field-alternating mode select (used only with the macro)
//  hcount      out  CW  current pixel
//  vcount      out  CW  current line
//  hs, vs      out  1   syncs, polarity set by HS_POL/VS_POL
//  hb, vb      out  1   horizontal and vertical blank, active high
//  de          out  1   ~hb & ~vb
//  line_start  out  1   1-clk pulse when hcount becomes 0
//  frame       out  1   1-clk pulse when hcount and vcount both become 0
//  field       out  1   current field; 0 when progressive
// BEHAVIOUR
//  - Reset (async, on reset_n=0):
//      hcount = vcount = 0; hb = vb = 1; de = 0; hs = ~HS_POL; vs = ~VS_POL
//      line_start = frame = field = 0; latched offsets = 0.
//  - All outputs are registered and updated only on clk edges with ce_pix=1.
//      Exception: line_start and frame are 1-clk pulses regardless of ce_pix width.
//      All outputs are aligned with the hcount/vcount values they describe (zero relative latency).
//  - hcount increments modulo H_TOTAL.
//      On wrap: vcount increments modulo the frame length (V_TOTAL, or per field below).
//  - Blanking:
//      hb = (hcount < H_ACT_START) | (hcount >= H_ACT_END)
//      vb = (vcount < V_ACT_START) | (vcount >= V_ACT_END)
//  - Horizontal sync:
//      hs active for hcount in [HSS, HSE), where HSS = (H_SYNC_START - ho) mod H_TOTAL and HSE = (H_SYNC_END - ho) mod H_TOTAL.
//      If HSE < HSS the active window wraps through hcount 0.
//  - Vertical sync:
//      vs active for vcount in [VSS, VSE), where VSS = (V_SYNC_START - vo) mod V_TOTAL and VSE = (V_SYNC_END - vo) mod V_TOTAL.
//      Same wrap rule as HS.
//      VS changes level only at hcount == HSS, so it is edge-aligned with HS.
//  - Offset arithmetic: sign-extend to CW+1 bits; add H_TOTAL (or V_TOTAL) when the result is negative; subtract it when the result is >= total.
//  - ho/vo are hoffs/voffs sampled on the ce_pix cycle where frame fires.
//      Input changes mid-frame have no effect until the next frame.
//  - frame and line_start pulse in the same clk as the counter wrap; they never both pulse without the counters being 0/0.
//  - Reset released mid-line: counting restarts from 0/0.
//      The first frame pulse comes after one full frame (no pulse at release).
//  - ce_pix held low: all outputs hold; pulses are not re-issued.
// CONFIGURATION
//  VIDEO_TIMING_INTERLACE_EN defined:
//    - While interlace=1, field toggles at every frame wrap.
//    - field=1 fields are V_TOTAL+1 lines long.
//    - In field 1, VS assert and deassert move to hcount == (HSS + H_TOTAL/2) mod H_TOTAL (half-line offset).
//    - interlace is sampled with the offsets.
//    - interlace=0 behaves exactly as progressive.
//  VIDEO_TIMING_INTERLACE_EN undefined:
//    - interlace is ignored; field is tied to 0; every frame is V_TOTAL lines.
// TESTING
//  1. Reset held, then released with ce_pix=1 continuous and defaults:
//     frame period 384*263 = 100992 clk; hb low for hcount 17..272; vb low for vcount 16..239.
//  2. hoffs=0:  hs low for hcount 309..340 (32 px).
//     hoffs=+7: hs low for 302..333.
//     hoffs=-8: hs low for 317..348.
//  3. voffs=+3 written mid-frame at vcount 100:
//     the current frame keeps vs on lines 250..252; the next frame has vs on lines 247..249.
//  4. ce_pix at 1/4 rate:
//     frame period 403968 clk; frame and line_start are exactly 1 clk wide; counters hold between enables.
//  5. reset_n pulsed low at hcount=200, vcount=120:
//     outputs take reset values asynchronously; after release, hcount=1 on the first ce_pix.
//  6. (macro) interlace=1:
//     field alternates; field-1 frame is 264 lines; field-1 VS edges occur at hcount 117.

Source files
------------

// File: rtl/video_timing_if.sv
// video_timing_if: raster timing bundle between the timing generator and its video consumers.
//   master (generator): in ce_pix, hoffs, voffs, interlace; out hcount, vcount, hs, vs, hb, vb, de, line_start, frame, field
//   slave  (consumer) : the mirror image of master
interface video_timing_if #(
  parameter int CW = 9
);
  logic          ce_pix;
  logic [3:0]    hoffs;
  logic [3:0]    voffs;
  logic          interlace;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hs;
  logic          vs;
  logic          hb;
  logic          vb;
  logic          de;
  logic          line_start;
  logic          frame;
  logic          field;
  modport master (
    input  ce_pix, hoffs, voffs, interlace,
    output hcount, vcount, hs, vs, hb, vb, de, line_start, frame, field
  );
  modport slave (
    output ce_pix, hoffs, voffs, interlace,
    input  hcount, vcount, hs, vs, hb, vb, de, line_start, frame, field
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator (counters, blanking, syncs, display enable).
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   vt       : video_timing_if.master -- ce_pix, signed hoffs/voffs, interlace in;
//              hcount, vcount, hs, vs, hb, vb, de, line_start, frame, field out
//   Optional interlace support is compiled in with VIDEO_TIMING_INTERLACE_EN; without it
//   interlace is ignored, field stays 0 and every frame is V_TOTAL lines.
module video_timing_gen #(
  parameter int CW           = 9,
  parameter int H_TOTAL      = 384,
  parameter int H_ACT_START  = 17,
  parameter int H_ACT_END    = 273,
  parameter int H_SYNC_START = 309,
  parameter int H_SYNC_END   = 341,
  parameter int V_TOTAL      = 263,
  parameter int V_ACT_START  = 16,
  parameter int V_ACT_END    = 240,
  parameter int V_SYNC_START = 250,
  parameter int V_SYNC_END   = 253,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0
) (
  input logic             clk,
  input logic             reset_n,
  video_timing_if.master  vt
);
  function automatic logic [CW-1:0] wrap(input int pos, input int total);
    int r;
    r = pos < 0 ? pos + total : (pos >= total ? pos - total : pos);
    return r[CW-1:0];
  endfunction
  function automatic logic in_win(input logic [CW-1:0] x, input logic [CW-1:0] s, input logic [CW-1:0] e);
    return s <= e ? (x >= s && x < e) : (x >= s || x < e);
  endfunction
  logic [CW-1:0] hcount, vcount, hn, vn, v_max, hss, hse, vss, vse, vpos;
  logic [3:0]    ho_q, vo_q, ho, vo;
  logic          hs, vs, hb, vb, de, line_start, frame, field, field_n;
  logic          h_wrap, v_last, f_wrap, hb_n, vb_n, hs_act, vs_act;
`ifdef VIDEO_TIMING_INTERLACE_EN
  // A field-1 frame carries the extra half-line pair, so it is one line longer.
  assign field_n = f_wrap ? vt.interlace & ~field : field;
  assign v_max   = field ? CW'(V_TOTAL) : CW'(V_TOTAL - 1);
  assign vpos    = field_n ? wrap(int'(hss) + H_TOTAL / 2, H_TOTAL) : hss;
`else
  assign field_n = vt.interlace & 1'b0;
  assign v_max   = CW'(V_TOTAL - 1);
  assign vpos    = hss;
`endif
  // Offsets apply from the frame they are sampled on, so the new frame's first pixel already uses them.
  always_comb begin
    h_wrap = hcount == CW'(H_TOTAL - 1);
    v_last = vcount == v_max;
    f_wrap = h_wrap & v_last;
    ho     = f_wrap ? vt.hoffs : ho_q;
    vo     = f_wrap ? vt.voffs : vo_q;
    hn     = h_wrap ? '0 : hcount + CW'(1);
    vn     = h_wrap ? (v_last ? '0 : vcount + CW'(1)) : vcount;
    hss    = wrap(H_SYNC_START - int'($signed(ho)), H_TOTAL);
    hse    = wrap(H_SYNC_END - int'($signed(ho)), H_TOTAL);
    vss    = wrap(V_SYNC_START - int'($signed(vo)), V_TOTAL);
    vse    = wrap(V_SYNC_END - int'($signed(vo)), V_TOTAL);
    hb_n   = (hn < CW'(H_ACT_START)) | (hn >= CW'(H_ACT_END));
    vb_n   = (vn < CW'(V_ACT_START)) | (vn >= CW'(V_ACT_END));
    hs_act = in_win(hn, hss, hse);
    vs_act = in_win(vn, vss, vse);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount     <= '0;
      vcount     <= '0;
      hb         <= 1'b1;
      vb         <= 1'b1;
      de         <= 1'b0;
      hs         <= ~HS_POL;
      vs         <= ~VS_POL;
      line_start <= 1'b0;
      frame      <= 1'b0;
      field      <= 1'b0;
      ho_q       <= '0;
      vo_q       <= '0;
    end else begin
      // Pulses are re-evaluated every clk so they last exactly one clk whatever the ce_pix duty.
      line_start <= vt.ce_pix & h_wrap;
      frame      <= vt.ce_pix & f_wrap;
      if (vt.ce_pix) begin
        hcount <= hn;
        vcount <= vn;
        hb     <= hb_n;
        vb     <= vb_n;
        de     <= ~hb_n & ~vb_n;
        hs     <= hs_act ? HS_POL : ~HS_POL;
        // VS only moves on the HS leading-edge column (half a line later in field 1).
        if (hn == vpos) vs <= vs_act ? VS_POL : ~VS_POL;
        ho_q   <= ho;
        vo_q   <= vo;
        field  <= field_n;
      end
    end
  end
  assign vt.hcount     = hcount;
  assign vt.vcount     = vcount;
  assign vt.hs         = hs;
  assign vt.vs         = vs;
  assign vt.hb         = hb;
  assign vt.vb         = vb;
  assign vt.de         = de;
  assign vt.line_start = line_start;
  assign vt.frame      = frame;
  assign vt.field      = field;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed bench for video_timing_gen (default build, interlace macro undefined).
//   Horizontal geometry is the default 384-pixel line; the frame is shortened to 24 lines
//   (active 2..17, VS 20..21) so several frames fit in a short run.
module tb_video_timing_gen;
  localparam int LIM   = 20000;
  localparam int FRAME = 384 * 24;
  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   cmp = 0;
  int   errs = 0;
  int   rel, fp, ls, n;
  int   ph;
  bit   qmode;
  int   hbf, hbc, hsf, hsc, def, dec;
  video_timing_if #(.CW(9)) vt();
  video_timing_gen #(
    .V_TOTAL(24), .V_ACT_START(2), .V_ACT_END(18), .V_SYNC_START(20), .V_SYNC_END(22)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vt(vt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    vt.ce_pix = qmode ? (ph == 3) : 1'b1;
    ph = (ph + 1) % 4;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_hv(input int h, input int v);
    n = 0;
    while (!(vt.hcount == 9'(h) && vt.vcount == 9'(v)) && n < LIM) begin
      tick();
      n++;
    end
    chk($sformatf("reach_%0d_%0d", h, v), n < LIM, 1);
  endtask
  task automatic wait_frame();
    n = 0;
    while (vt.frame !== 1'b1 && n < LIM) begin
      tick();
      n++;
    end
    chk("frame_reached", n < LIM, 1);
    chk("frame_period", cyc - fp, FRAME);
    chk("frame_h0", vt.hcount, 0);
    chk("frame_v0", vt.vcount, 0);
    chk("frame_ls", vt.line_start, 1);
    fp = cyc;
  endtask
  task automatic scan_line();
    hbf = -1; hbc = 0; hsf = -1; hsc = 0; def = -1; dec = 0;
    for (int i = 0; i < 384; i++) begin
      if (vt.hb == 1'b0) begin if (hbf < 0) hbf = int'(vt.hcount); hbc++; end
      if (vt.hs == 1'b0) begin if (hsf < 0) hsf = int'(vt.hcount); hsc++; end
      if (vt.de == 1'b1) begin if (def < 0) def = int'(vt.hcount); dec++; end
      tick();
    end
  endtask
  initial begin
    reset_n = 1'b0; vt.ce_pix = 1'b1; vt.hoffs = 4'd0; vt.voffs = 4'd0; vt.interlace = 1'b0;
    qmode = 1'b0; ph = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_h", vt.hcount, 0);
    chk("rst_v", vt.vcount, 0);
    chk("rst_hb", vt.hb, 1);
    chk("rst_vb", vt.vb, 1);
    chk("rst_de", vt.de, 0);
    chk("rst_hs", vt.hs, 1);
    chk("rst_vs", vt.vs, 1);
    chk("rst_ls", vt.line_start, 0);
    chk("rst_frame", vt.frame, 0);
    chk("rst_field", vt.field, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    @(posedge clk);
    #1;
    chk("rel_h", vt.hcount, 1);
    chk("rel_v", vt.vcount, 0);
    chk("rel_frame", vt.frame, 0);
    fp = rel;
    wait_frame();
    tick();
    chk("frame_width", vt.frame, 0);
    chk("ls_width", vt.line_start, 0);
    wait_hv(0, 1);
    chk("vb_line1", vt.vb, 1);
    scan_line();
    chk("hb_first", hbf, 17);
    chk("hb_count", hbc, 256);
    chk("hs_first_0", hsf, 309);
    chk("hs_count_0", hsc, 32);
    chk("de_line1", dec, 0);
    chk("vb_line2", vt.vb, 0);
    wait_hv(0, 5);
    scan_line();
    chk("de_first", def, 17);
    chk("de_count", dec, 256);
    wait_hv(0, 10);
    vt.voffs = 4'd3;
    wait_hv(0, 17);
    chk("vb_line17", vt.vb, 0);
    wait_hv(0, 18);
    chk("vb_line18", vt.vb, 1);
    wait_hv(308, 20);
    chk("vs_pre_20", vt.vs, 1);
    tick();
    chk("vs_on_20", vt.vs, 0);
    chk("hs_on_309", vt.hs, 0);
    wait_hv(308, 22);
    chk("vs_pre_22", vt.vs, 0);
    tick();
    chk("vs_off_22", vt.vs, 1);
    wait_frame();
    wait_hv(308, 17);
    chk("vs_pre_17", vt.vs, 1);
    tick();
    chk("vs_on_17", vt.vs, 0);
    wait_hv(308, 19);
    chk("vs_pre_19", vt.vs, 0);
    tick();
    chk("vs_off_19", vt.vs, 1);
    wait_hv(310, 20);
    chk("vs_idle_20", vt.vs, 1);
    wait_hv(0, 21);
    vt.hoffs = 4'd7;
    wait_frame();
    wait_hv(0, 1);
    scan_line();
    chk("hs_first_p7", hsf, 302);
    chk("hs_count_p7", hsc, 32);
    vt.hoffs = 4'b1000;
    wait_hv(301, 17);
    chk("vs_pre_302", vt.vs, 1);
    tick();
    chk("vs_on_302", vt.vs, 0);
    wait_frame();
    wait_hv(0, 1);
    scan_line();
    chk("hs_first_m8", hsf, 317);
    chk("hs_count_m8", hsc, 32);
    chk("hb_first_m8", hbf, 17);
    chk("hb_count_m8", hbc, 256);
    wait_hv(0, 3);
    chk("q_ls_start", vt.line_start, 1);
    ls = cyc;
    qmode = 1'b1;
    ph = 0;
    tick();
    chk("q_ls_width", vt.line_start, 0);
    chk("q_hold_1", vt.hcount, 0);
    tick();
    tick();
    chk("q_hold_3", vt.hcount, 0);
    tick();
    chk("q_step", vt.hcount, 1);
    n = 0;
    while (vt.line_start !== 1'b1 && n < LIM) begin
      tick();
      n++;
    end
    chk("q_ls_reached", n < LIM, 1);
    chk("q_line_period", cyc - ls, 1536);
    chk("q_h0", vt.hcount, 0);
    chk("q_v4", vt.vcount, 4);
    tick();
    chk("q_ls_width2", vt.line_start, 0);
    chk("q_hold_h", vt.hcount, 0);
    qmode = 1'b0;
    wait_hv(200, 12);
    chk("pre_rst_de", vt.de, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_h", vt.hcount, 0);
    chk("arst_v", vt.vcount, 0);
    chk("arst_de", vt.de, 0);
    chk("arst_hb", vt.hb, 1);
    chk("arst_vb", vt.vb, 1);
    chk("arst_hs", vt.hs, 1);
    chk("arst_vs", vt.vs, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel2_h", vt.hcount, 1);
    chk("rel2_v", vt.vcount, 0);
    chk("rel2_frame", vt.frame, 0);
    chk("field_prog", vt.field, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
